pw_lock_param: RTL and testbench

- Parametrised successor to the fixed four-switch password lock.
- Accepts a code of configurable length, entered as one-at-a-time switch presses on an NUM_SW-wide switch bank.
- Adds retry counting, a timed lockout after repeated failures, an inter-press entry timeout and an explicit relock input.
- Sits between the board switches and the seven-segment/LED status logic; outputs are raw status, not display-encoded.

---
 rtl/pw_lock_param.sv | 171 +++++++++++++++++
 tb/tb_pw_lock_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_lock_param.sv
// Parametrised switch-bank password lock with retry counting, timed lockout,
// entry timeout and relock. Define PW_SYNC_EN to add a two-flop input synchroniser.
module pw_lock_param #(
  parameter int NUM_SW         = 10,
  parameter int CODE_LEN       = 4,
  parameter logic [CODE_LEN*((NUM_SW > 1) ? $clog2(NUM_SW) : 1)-1:0] CODE = 16'h3210,
  parameter int MAX_TRIES      = 3,
  parameter int LOCK_CYCLES    = 100,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_SW-1:0] sw_i,
  input  logic              relock_i,
  output logic [2:0]        state_o,
  output logic [3:0]        entered_o,
  output logic [3:0]        tries_left_o,
  output logic              open_o,
  output logic              alarm_o
);

  localparam int IDX_W  = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;
  localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         entered_q, entered_d;
  logic [3:0]         tries_q, tries_d;
  logic               ok_q, ok_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [LOCK_W-1:0]  lock_q, lock_d;
  logic [NUM_SW-1:0]  sw_prev_q;
  logic [NUM_SW-1:0]  sw_det;
  logic               press;
  logic               one_hot;
  logic [IDX_W-1:0]   sw_idx;
  logic [IDX_W-1:0]   exp_digit;
  logic               digit_ok;

`ifdef PW_SYNC_EN
  logic [NUM_SW-1:0] sync1_q, sync2_q;

  // Reset to all ones so a switch held through reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sw_det = sync2_q;
`else
  assign sw_det = sw_i;
`endif

  assign press   = (sw_prev_q == '0) && (sw_det != '0);
  assign one_hot = (sw_det != '0) && ((sw_det & (sw_det - 1'b1)) == '0);

  always_comb begin
    sw_idx    = '0;
    exp_digit = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sw_det[i]) sw_idx = IDX_W'(i);
    end
    for (int i = 0; i < CODE_LEN; i++) begin
      if (entered_q == 4'(i)) exp_digit = CODE[i*IDX_W +: IDX_W];
    end
  end

  // A multi-bit press can never match, whatever its highest set bit is.
  assign digit_ok = one_hot && (sw_idx == exp_digit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      entered_q <= '0;
      tries_q   <= 4'(MAX_TRIES);
      ok_q      <= 1'b0;
      tmo_q     <= '0;
      lock_q    <= '0;
      sw_prev_q <= '1;
    end else begin
      state_q   <= state_d;
      entered_q <= entered_d;
      tries_q   <= tries_d;
      ok_q      <= ok_d;
      tmo_q     <= tmo_d;
      lock_q    <= lock_d;
      sw_prev_q <= sw_det;
    end
  end

  always_comb begin
    state_d   = state_q;
    entered_d = entered_q;
    tries_d   = tries_q;
    ok_d      = ok_q;
    tmo_d     = tmo_q;
    lock_d    = lock_q;
    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          entered_d = 4'd1;
          ok_d      = digit_ok;
          tmo_d     = '0;
          state_d   = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (press) begin
          entered_d = entered_q + 4'd1;
          ok_d      = ok_q & digit_ok;
          tmo_d     = '0;
          if (entered_q + 4'd1 == 4'(CODE_LEN)) state_d = S_CHECK;
        end else if (tmo_q >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_IDLE;
          entered_d = '0;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        entered_d = '0;
        if (ok_q) begin
          state_d = S_OPEN;
          tries_d = 4'(MAX_TRIES);
        end else begin
          state_d = S_FAIL;
          tries_d = (tries_q != 4'd0) ? tries_q - 4'd1 : 4'd0;
        end
      end
      S_FAIL: begin
        lock_d  = '0;
        state_d = (tries_q == 4'd0) ? S_LOCKOUT : S_IDLE;
      end
      S_LOCKOUT: begin
        if (lock_q >= LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          tries_d = 4'(MAX_TRIES);
          lock_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      S_OPEN: begin
        if (relock_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o      = state_q;
  assign entered_o    = entered_q;
  assign tries_left_o = tries_q;
  assign open_o       = (state_q == S_OPEN);
  assign alarm_o      = (state_q == S_LOCKOUT);

endmodule

// File: tb/tb_pw_lock_param.sv
// Self-checking bench for pw_lock_param: directed test-plan steps followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_pw_lock_param;

`ifdef PW_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [15:0] CODE_VEC = 16'h3210;
  localparam int CODE_LEN = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYCLES = 100;
  localparam int TIMEOUT_CYCLES = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       relock = 1'b0;
  logic [9:0] sw = '0;
  logic [2:0] state;
  logic [3:0] entered;
  logic [3:0] triesLeft;
  logic       openLock;
  logic       alarm;

  int assertCount = 0;
  int failCount = 0;

  int mState = 0;
  logic [9:0] digits[$];
  int mTries = MAX_TRIES;
  int mIdle = 0;
  int mLock = 0;
  logic [9:0] mPrev = '1;
  logic [9:0] mSync1 = '1;
  logic [9:0] mSync2 = '1;

  pw_lock_param dut (
    .clk_i(clk),
    .rst_i(rst),
    .sw_i(sw),
    .relock_i(relock),
    .state_o(state),
    .entered_o(entered),
    .tries_left_o(triesLeft),
    .open_o(openLock),
    .alarm_o(alarm)
  );

  always #10 clk = ~clk;

  function automatic int codeDig(input int i);
    return int'((CODE_VEC >> (4 * i)) & 16'hF);
  endfunction

  // Reference model: remembers the raw switch patterns of the current attempt
  // and judges the whole attempt at once against the one-hot code digits.
  task automatic modelStep(input logic [9:0] s, input logic r, input logic rs);
    logic [9:0] det;
    bit press;
    bit good;
    if (rs) begin
      mState = 0; digits.delete(); mTries = MAX_TRIES; mIdle = 0; mLock = 0;
      mPrev = '1; mSync1 = '1; mSync2 = '1;
      return;
    end
    det = (SYNC_LAT != 0) ? mSync2 : s;
    press = (mPrev == 10'd0) && (det != 10'd0);
    mPrev = det;
    mSync2 = mSync1;
    mSync1 = s;
    case (mState)
      0: if (press) begin
        digits.push_back(det);
        mIdle = 0;
        mState = (CODE_LEN == 1) ? 2 : 1;
      end
      1: begin
        if (press) begin
          digits.push_back(det);
          mIdle = 0;
          if (digits.size() == CODE_LEN) mState = 2;
        end else begin
          mIdle++;
          if (mIdle == TIMEOUT_CYCLES) begin
            mState = 0; digits.delete(); mIdle = 0;
          end
        end
      end
      2: begin
        good = 1'b1;
        foreach (digits[i]) if (digits[i] != (10'd1 << codeDig(i))) good = 1'b0;
        digits.delete();
        if (good) begin
          mState = 3; mTries = MAX_TRIES;
        end else begin
          mState = 4; mTries = (mTries > 0) ? mTries - 1 : 0;
        end
      end
      3: if (r) mState = 0;
      4: begin
        mLock = 0;
        mState = (mTries == 0) ? 5 : 0;
      end
      5: begin
        mLock++;
        if (mLock == LOCK_CYCLES) begin
          mState = 0; mTries = MAX_TRIES;
        end
      end
      default: mState = 0;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] s, input logic r, input logic rs);
    sw = s; relock = r; rst = rs;
    @(posedge clk);
    modelStep(s, r, rs);
    #1;
    checkOutput("state", 32'(state), 32'(mState));
    checkOutput("entered", 32'(entered), 32'(digits.size()));
    checkOutput("tries_left", 32'(triesLeft), 32'(mTries));
    checkOutput("open", 32'(openLock), 32'(mState == 3));
    checkOutput("alarm", 32'(alarm), 32'(mState == 5));
  endtask

  // Drives a switch pattern until the lock has sampled it as a press.
  task automatic pressDigit(input logic [9:0] v);
    repeat (1 + SYNC_LAT) applyStimulus(v, 1'b0, 1'b0);
  endtask

  task automatic releaseDigit(input logic [9:0] v);
    applyStimulus(v, 1'b0, 1'b0);
    applyStimulus(10'd0, 1'b0, 1'b0);
  endtask

  task automatic wrongAttempt();
    pressDigit(10'h002); releaseDigit(10'h002);
    pressDigit(10'h001); releaseDigit(10'h001);
    pressDigit(10'h004); releaseDigit(10'h004);
    pressDigit(10'h008); releaseDigit(10'h008);
  endtask

  initial begin
    int cnt;
    int pick;
    int hold;
    logic [9:0] v;
    logic r;
    logic rs;

    // Held switch through reset must not register as a press.
    repeat (2) applyStimulus(10'h001, 1'b0, 1'b1);
    checkOutput("reset_state", 32'(state), 32'd0);
    checkOutput("reset_tries", 32'(triesLeft), 32'd3);
    checkOutput("reset_open", 32'(openLock), 32'd0);
    checkOutput("reset_alarm", 32'(alarm), 32'd0);
    repeat (4) applyStimulus(10'h001, 1'b0, 1'b0);
    applyStimulus(10'd0, 1'b0, 1'b0);
    checkOutput("held_sw_state", 32'(state), 32'd0);
    checkOutput("held_sw_entered", 32'(entered), 32'd0);
    repeat (2) applyStimulus(10'd0, 1'b0, 1'b0);

    // Correct code.
    for (int k = 0; k < 3; k++) begin
      v = 10'd1 << k;
      pressDigit(v);
      checkOutput("ok_entered", 32'(entered), 32'(k + 1));
      releaseDigit(v);
    end
    pressDigit(10'h008);
    checkOutput("ok_check_state", 32'(state), 32'd2);
    checkOutput("ok_check_entered", 32'(entered), 32'd4);
    applyStimulus(10'h008, 1'b0, 1'b0);
    checkOutput("ok_open_state", 32'(state), 32'd3);
    checkOutput("ok_open", 32'(openLock), 32'd1);
    checkOutput("ok_tries", 32'(triesLeft), 32'd3);
    applyStimulus(10'h004, 1'b0, 1'b0);
    checkOutput("open_ignores_press", 32'(state), 32'd3);
    applyStimulus(10'd0, 1'b1, 1'b0);
    checkOutput("relock_state", 32'(state), 32'd0);
    checkOutput("relock_open", 32'(openLock), 32'd0);
    repeat (3) applyStimulus(10'd0, 1'b0, 1'b0);

    // Wrong digit first: no early abort, then FAIL for one cycle.
    pressDigit(10'h002); releaseDigit(10'h002);
    pressDigit(10'h001); releaseDigit(10'h001);
    pressDigit(10'h004); releaseDigit(10'h004);
    pressDigit(10'h008);
    checkOutput("wrong_entered", 32'(entered), 32'd4);
    checkOutput("wrong_check", 32'(state), 32'd2);
    applyStimulus(10'h008, 1'b0, 1'b0);
    checkOutput("wrong_fail", 32'(state), 32'd4);
    checkOutput("wrong_tries", 32'(triesLeft), 32'd2);
    applyStimulus(10'd0, 1'b0, 1'b0);
    checkOutput("wrong_idle", 32'(state), 32'd0);
    checkOutput("wrong_open", 32'(openLock), 32'd0);

    // Two more failures reach lockout; presses during lockout are ignored.
    wrongAttempt();
    checkOutput("second_fail_tries", 32'(triesLeft), 32'd1);
    wrongAttempt();
    cnt = 0;
    while (state === 3'd5 && cnt < 300) begin
      cnt++;
      applyStimulus(((cnt % 4) == 1) ? (10'd1 << $urandom_range(0, 9)) : 10'd0, 1'b0, 1'b0);
    end
    checkOutput("lockout_cycles", 32'(cnt), 32'(LOCK_CYCLES));
    checkOutput("lockout_exit_state", 32'(state), 32'd0);
    checkOutput("lockout_exit_tries", 32'(triesLeft), 32'd3);
    repeat (3) applyStimulus(10'd0, 1'b0, 1'b0);

    // Timeout: one press then idle; the attempt is dropped without a failure.
    pressDigit(10'h001);
    checkOutput("tmo_entered", 32'(entered), 32'd1);
    repeat (TIMEOUT_CYCLES - 1) applyStimulus(10'd0, 1'b0, 1'b0);
    checkOutput("tmo_before", 32'(state), 32'd1);
    applyStimulus(10'd0, 1'b0, 1'b0);
    checkOutput("tmo_state", 32'(state), 32'd0);
    checkOutput("tmo_entered_clr", 32'(entered), 32'd0);
    checkOutput("tmo_tries", 32'(triesLeft), 32'd3);
    repeat (2) applyStimulus(10'd0, 1'b0, 1'b0);

    // Multi-bit first press counts as a wrong digit.
    pressDigit(10'h003); releaseDigit(10'h003);
    pressDigit(10'h002); releaseDigit(10'h002);
    pressDigit(10'h004); releaseDigit(10'h004);
    pressDigit(10'h008); releaseDigit(10'h008);
    checkOutput("multi_tries", 32'(triesLeft), 32'd2);
    checkOutput("multi_open", 32'(openLock), 32'd0);

    // Reset mid-entry.
    pressDigit(10'h001); releaseDigit(10'h001);
    pressDigit(10'h002);
    checkOutput("rst_mid_entered_pre", 32'(entered), 32'd2);
    applyStimulus(10'd0, 1'b0, 1'b1);
    checkOutput("rst_mid_state", 32'(state), 32'd0);
    checkOutput("rst_mid_entered", 32'(entered), 32'd0);
    checkOutput("rst_mid_tries", 32'(triesLeft), 32'd3);
    repeat (3) applyStimulus(10'd0, 1'b0, 1'b0);

    // Randomized phase, biased toward the right digit so OPEN is reached often.
    v = '0;
    for (int n = 0; n < 1500; n++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 3) v = 10'd0;
      else if (pick <= 6) v = (digits.size() < CODE_LEN) ? (10'd1 << codeDig(digits.size())) : 10'd0;
      else if (pick == 7) v = 10'd1 << $urandom_range(0, 9);
      else if (pick == 8) v = 10'($urandom_range(0, 1023));
      r = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) == 0);
      hold = $urandom_range(1, 2 + SYNC_LAT);
      repeat (hold) applyStimulus(v, r, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
